uc_seq: RTL and testbench
=========================

UC_SEQ -- requirements
Module: uc_seq

Interface
REQ-001 Parameter FETCH_CYCLES, default 1, SHALL set the number of wait cycles per instruction fetch (range 1..15).
REQ-002 Parameter COUNT_W, default 16, SHALL set the width of the retired-instruction counter.
REQ-003 clk  input  1  SHALL be the single clock; all state changes occur on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-high reset.
REQ-005 opcode  input  6  SHALL be the current instruction opcode from the datapath.
REQ-006 z  input  1  SHALL be the datapath zero flag.
REQ-007 run  input  1  SHALL be the level request for continuous execution.
REQ-008 step_req  input  1  SHALL be a one-cycle pulse requesting a single instruction.
REQ-009 s_inc, s_inm, we3, wez  output  1 each  SHALL be the datapath controls: PC source, immediate select, register write, flag write.
REQ-010 op_alu  output  3  SHALL be the ALU operation select.
REQ-011 pc_we  output  1  SHALL be the PC load enable; the PC holds when it is 0.
REQ-012 step_ack  output  1  SHALL pulse for one cycle on completion of a single step.
REQ-013 halted  output  1  SHALL be high while in HALT.
REQ-014 instr_count  output  COUNT_W  SHALL be the retired-instruction count.

Function
REQ-015 The FSM SHALL have the states IDLE, FETCH, EXEC and HALT.
REQ-016 IDLE: run=1 -> FETCH (continuous); otherwise step_req=1 -> FETCH with the step flag set; run wins if both are high.
REQ-017 FETCH SHALL last exactly FETCH_CYCLES cycles via a down-counter and then go to EXEC.
REQ-018 EXEC SHALL last one cycle; it is the only state in which we3, wez or pc_we may be 1.
REQ-019 Decode in EXEC: opcode[5]=0 -> ALU op: op_alu=opcode[4:2], we3=1, wez=1, s_inm=0, s_inc=1, pc_we=1.
REQ-020 opcode[5:2]=1000 -> load immediate: s_inm=1, we3=1, wez=0, s_inc=1, pc_we=1.
REQ-021 opcode[5:2]=1001 -> jump: s_inc=0, pc_we=1.
REQ-022 opcode[5:2]=1010 -> jump-if-zero: s_inc=~z, pc_we=1.
REQ-023 opcode[5:2]=1011 -> jump-if-not-zero: s_inc=z, pc_we=1.
REQ-024 opcode=111111 -> halt: pc_we=0, no writes; next state HALT.
REQ-025 Any other opcode -> nop: s_inc=1, pc_we=1, no writes.
REQ-026 Exit from EXEC for non-halt opcodes: step flag set -> IDLE, step_ack=1 in the next cycle, step flag cleared; else run=1 -> FETCH; else IDLE.
REQ-027 instr_count SHALL increment by 1 at the end of every EXEC cycle, halt included, and wrap modulo 2^COUNT_W.
REQ-028 Outside EXEC: s_inc=1, s_inm=0, we3=0, wez=0, pc_we=0, op_alu=000.
REQ-029 step_req pulses SHALL be ignored outside IDLE.
REQ-030 Changes on run during FETCH or EXEC SHALL take effect only at the EXEC exit decision.
REQ-031 HALT SHALL be absorbing and exited only by reset; run and step_req are ignored there.
REQ-032 Decode outputs SHALL be combinational from state, opcode and z; step_ack, halted and instr_count SHALL be registered.

Reset
REQ-033 Asserting reset SHALL immediately (asynchronously) force: state IDLE, step flag 0, fetch counter 0, step_ack 0, halted 0, instr_count 0, and all control outputs to their REQ-028 values.
REQ-034 Reset asserted during FETCH or EXEC SHALL abort the instruction with no write enables asserted afterwards and no count increment.

Structure
REQ-035 Package cpu_pkg SHALL hold the state enum, the opcode field constants (ALU, LI, J, JZ, JNZ, HALT) and the op_alu width.
REQ-036 Combinational decode SHALL be a sub-module uc_dec (inputs opcode and z; outputs the control set); uc_seq adds gating and the FSM.

Verification
REQ-037 With FETCH_CYCLES=2, run=1 and opcode=000100: each instruction takes 3 cycles; we3=wez=pc_we=1 with op_alu=001 only in the third cycle; instr_count=3 after 9 cycles.
REQ-038 step_req pulse with run=0 and opcode=100000: one EXEC with s_inm=1 and we3=1, then step_ack=1 for one cycle and return to IDLE; a second step_req during FETCH is ignored.
REQ-039 opcode=101000: with z=1, EXEC gives s_inc=0; with z=0, s_inc=1; with opcode=101100, the results are inverted.
REQ-040 opcode=111111 under run: halted=1 from the cycle after EXEC; pc_we stays 0 forever; run and step_req have no effect; reset clears halted and instr_count.
REQ-041 Reset asserted mid-FETCH, then mid-EXEC: outputs return to the REQ-028 values in the same cycle, and instr_count is unchanged by the aborted instruction.
REQ-042 With COUNT_W=4, retire 17 instructions: instr_count=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and opcode field constants for the micro-sequencer and its decoder.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_HALT  = 2'd3
  } state_t;

  localparam int OP_ALU_W = 3;

  // ALU ops are identified by opcode[5]; the others by opcode[5:2] or the full opcode.
  localparam logic       OPC_ALU_MSB = 1'b0;
  localparam logic [3:0] OPC_LI      = 4'b1000;
  localparam logic [3:0] OPC_J       = 4'b1001;
  localparam logic [3:0] OPC_JZ      = 4'b1010;
  localparam logic [3:0] OPC_JNZ     = 4'b1011;
  localparam logic [5:0] OPC_HALT    = 6'b111111;

  typedef struct packed {
    logic                s_inc;
    logic                s_inm;
    logic                we3;
    logic                wez;
    logic                pc_we;
    logic [OP_ALU_W-1:0] op_alu;
  } ctrl_t;

  // Control set driven whenever no instruction is executing.
  function automatic ctrl_t ctrl_idle();
    ctrl_t c;
    c.s_inc  = 1'b1;
    c.s_inm  = 1'b0;
    c.we3    = 1'b0;
    c.wez    = 1'b0;
    c.pc_we  = 1'b0;
    c.op_alu = 3'b000;
    return c;
  endfunction

endpackage

// File: rtl/uc_dec.sv
// Combinational instruction decoder: opcode and zero flag to datapath controls.
module uc_dec
  import cpu_pkg::*;
(
  input  logic [5:0]          opcode,
  input  logic                z,
  output logic                s_inc,
  output logic                s_inm,
  output logic                we3,
  output logic                wez,
  output logic                pc_we,
  output logic [OP_ALU_W-1:0] op_alu,
  output logic                is_halt
);

  ctrl_t ctrl_s;

  // Decode priority: full halt match first, then ALU class, then the 4-bit groups.
  always_comb begin
    ctrl_s       = ctrl_idle();
    ctrl_s.pc_we = 1'b1;
    is_halt      = 1'b0;
    if (opcode == OPC_HALT) begin
      ctrl_s.pc_we = 1'b0;
      is_halt      = 1'b1;
    end else if (opcode[5] == OPC_ALU_MSB) begin
      ctrl_s.op_alu = opcode[4:2];
      ctrl_s.we3    = 1'b1;
      ctrl_s.wez    = 1'b1;
    end else begin
      case (opcode[5:2])
        OPC_LI: begin
          ctrl_s.s_inm = 1'b1;
          ctrl_s.we3   = 1'b1;
        end
        OPC_J:   ctrl_s.s_inc = 1'b0;
        OPC_JZ:  ctrl_s.s_inc = ~z;
        OPC_JNZ: ctrl_s.s_inc = z;
        default: ctrl_s.s_inc = 1'b1;
      endcase
    end
  end

  assign s_inc  = ctrl_s.s_inc;
  assign s_inm  = ctrl_s.s_inm;
  assign we3    = ctrl_s.we3;
  assign wez    = ctrl_s.wez;
  assign pc_we  = ctrl_s.pc_we;
  assign op_alu = ctrl_s.op_alu;

endmodule

// File: rtl/uc_seq.sv
// Micro-sequencer: IDLE/FETCH/EXEC/HALT control FSM with single-step support,
// gating the decoder so write enables only appear in EXEC.
module uc_seq
  import cpu_pkg::*;
#(
  parameter int FETCH_CYCLES = 1,
  parameter int COUNT_W      = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          opcode,
  input  logic                z,
  input  logic                run,
  input  logic                step_req,
  output logic                s_inc,
  output logic                s_inm,
  output logic                we3,
  output logic                wez,
  output logic [OP_ALU_W-1:0] op_alu,
  output logic                pc_we,
  output logic                step_ack,
  output logic                halted,
  output logic [COUNT_W-1:0]  instr_count
);

  localparam logic [3:0]         FETCH_LOAD = 4'(FETCH_CYCLES - 1);
  localparam logic [COUNT_W-1:0] COUNT_ONE  = {{(COUNT_W-1){1'b0}}, 1'b1};

  state_t             state_r;
  state_t             next_state_s;
  logic               step_r;
  logic [3:0]         fetch_cnt_r;
  logic               step_ack_r;
  logic               halted_r;
  logic [COUNT_W-1:0] count_r;
  ctrl_t              dec_s;
  ctrl_t              ctrl_s;
  logic               dec_halt_s;

  uc_dec u_dec (
    .opcode  (opcode),
    .z       (z),
    .s_inc   (dec_s.s_inc),
    .s_inm   (dec_s.s_inm),
    .we3     (dec_s.we3),
    .wez     (dec_s.wez),
    .pc_we   (dec_s.pc_we),
    .op_alu  (dec_s.op_alu),
    .is_halt (dec_halt_s)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= next_state_s;
  end

  // Next-state logic; run is only sampled in IDLE and at the EXEC exit.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (run || step_req) next_state_s = ST_FETCH;
        else                 next_state_s = ST_IDLE;
      end
      ST_FETCH: begin
        if (fetch_cnt_r == 4'd0) next_state_s = ST_EXEC;
        else                     next_state_s = ST_FETCH;
      end
      ST_EXEC: begin
        if (dec_halt_s)  next_state_s = ST_HALT;
        else if (step_r) next_state_s = ST_IDLE;
        else if (run)    next_state_s = ST_FETCH;
        else             next_state_s = ST_IDLE;
      end
      ST_HALT: next_state_s = ST_HALT;
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Output logic: decoder controls pass through only during EXEC.
  always_comb begin
    if (state_r == ST_EXEC) ctrl_s = dec_s;
    else                    ctrl_s = ctrl_idle();
  end

  // Fetch wait counter, loaded on every entry into FETCH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                              fetch_cnt_r <= 4'd0;
    else if (state_r != ST_FETCH && next_state_s == ST_FETCH) fetch_cnt_r <= FETCH_LOAD;
    else if (state_r == ST_FETCH && fetch_cnt_r != 4'd0)     fetch_cnt_r <= fetch_cnt_r - 4'd1;
    else                                                    fetch_cnt_r <= fetch_cnt_r;
  end

  // Step flag: captured only from IDLE when run does not take priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                          step_r <= 1'b0;
    else if (state_r == ST_IDLE && !run && step_req)   step_r <= 1'b1;
    else if (state_r == ST_EXEC)                        step_r <= 1'b0;
    else                                                step_r <= step_r;
  end

  // Registered status: step acknowledge, halt indication and retired count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_ack_r <= 1'b0;
      halted_r   <= 1'b0;
      count_r    <= {COUNT_W{1'b0}};
    end else begin
      step_ack_r <= (state_r == ST_EXEC) && step_r && !dec_halt_s;
      halted_r   <= (next_state_s == ST_HALT);
      if (state_r == ST_EXEC) count_r <= count_r + COUNT_ONE;
      else                    count_r <= count_r;
    end
  end

  assign s_inc       = ctrl_s.s_inc;
  assign s_inm       = ctrl_s.s_inm;
  assign we3         = ctrl_s.we3;
  assign wez         = ctrl_s.wez;
  assign pc_we       = ctrl_s.pc_we;
  assign op_alu      = ctrl_s.op_alu;
  assign step_ack    = step_ack_r;
  assign halted      = halted_r;
  assign instr_count = count_r;

endmodule

// File: tb/tb_uc_seq.sv
// Directed bench for uc_seq (FETCH_CYCLES=2, COUNT_W=4): decode table via single
// steps, then hand-written run, step, reset-abort, halt and counter-wrap sequences.
module tb_uc_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       z;
  logic       run;
  logic       step_req;
  logic       s_inc, s_inm, we3, wez, pc_we, step_ack, halted;
  logic [2:0] op_alu;
  logic [3:0] instr_count;
  logic [7:0] ctrl;

  int total = 0;
  int bad   = 0;
  int n_exec;
  int exp_cnt;

  localparam logic [7:0] IDLE_CTRL = 8'b10000000;

  typedef struct {
    logic [5:0] op;
    logic       zf;
    logic [7:0] exp;  // {s_inc, s_inm, we3, wez, pc_we, op_alu}
    string      name;
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  assign ctrl = {s_inc, s_inm, we3, wez, pc_we, op_alu};

  uc_seq #(.FETCH_CYCLES(2), .COUNT_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .z           (z),
    .run         (run),
    .step_req    (step_req),
    .s_inc       (s_inc),
    .s_inm       (s_inm),
    .we3         (we3),
    .wez         (wez),
    .op_alu      (op_alu),
    .pc_we       (pc_we),
    .step_ack    (step_ack),
    .halted      (halted),
    .instr_count (instr_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    vecs[0]  = '{6'b000100, 1'b0, 8'b10111001, "alu_001"};
    vecs[1]  = '{6'b011100, 1'b1, 8'b10111111, "alu_111"};
    vecs[2]  = '{6'b100000, 1'b0, 8'b11101000, "li"};
    vecs[3]  = '{6'b100100, 1'b1, 8'b00001000, "j"};
    vecs[4]  = '{6'b101000, 1'b1, 8'b00001000, "jz_z1"};
    vecs[5]  = '{6'b101000, 1'b0, 8'b10001000, "jz_z0"};
    vecs[6]  = '{6'b101100, 1'b1, 8'b10001000, "jnz_z1"};
    vecs[7]  = '{6'b101100, 1'b0, 8'b00001000, "jnz_z0"};
    vecs[8]  = '{6'b110000, 1'b0, 8'b10001000, "nop_1100"};
    vecs[9]  = '{6'b111110, 1'b1, 8'b10001000, "nop_111110"};
    vecs[10] = '{6'b111011, 1'b0, 8'b10001000, "nop_1110"};

    reset = 1'b1; run = 1'b0; step_req = 1'b0; z = 1'b0; opcode = 6'b000000;
    tick();
    chk("reset_ctrl", 32'(ctrl), 32'(IDLE_CTRL));
    chk("reset_halted", 32'(halted), 32'd0);
    chk("reset_count", 32'(instr_count), 32'd0);
    chk("reset_ack", 32'(step_ack), 32'd0);
    reset = 1'b0;

    // Decode table, one single step per vector.
    exp_cnt = 0;
    for (int i = 0; i < 11; i++) begin
      opcode = vecs[i].op; z = vecs[i].zf; step_req = 1'b1;
      tick();
      step_req = 1'b0;
      chk({vecs[i].name, "_fetch_ctrl"}, 32'(ctrl), 32'(IDLE_CTRL));
      chk({vecs[i].name, "_fetch_ack"}, 32'(step_ack), 32'd0);
      tick();
      tick();
      chk({vecs[i].name, "_exec"}, 32'(ctrl), 32'(vecs[i].exp));
      tick();
      exp_cnt = (exp_cnt + 1) % 16;
      chk({vecs[i].name, "_ack"}, 32'(step_ack), 32'd1);
      chk({vecs[i].name, "_count"}, 32'(instr_count), 32'(exp_cnt));
      chk({vecs[i].name, "_idle_ctrl"}, 32'(ctrl), 32'(IDLE_CTRL));
    end

    // Continuous run, 3 cycles per instruction.
    reset = 1'b1; tick(); reset = 1'b0;
    opcode = 6'b000100; z = 1'b0; run = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      chk($sformatf("run_cyc%0d", c), 32'(ctrl), (c % 3 == 0) ? 32'h0B9 : 32'(IDLE_CTRL));
      if (c == 9) run = 1'b0;
    end
    tick();
    chk("run_count3", 32'(instr_count), 32'd3);
    chk("run_stop_ctrl", 32'(ctrl), 32'(IDLE_CTRL));

    // Single step with a second request during FETCH.
    opcode = 6'b100000; step_req = 1'b1;
    tick();
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    tick();
    chk("step_exec", 32'(ctrl), 32'h0E8);
    tick();
    chk("step_ack", 32'(step_ack), 32'd1);
    chk("step_count", 32'(instr_count), 32'd4);
    tick();
    chk("step_ack_drop", 32'(step_ack), 32'd0);
    tick();
    tick();
    chk("step_ignored_ctrl", 32'(ctrl), 32'(IDLE_CTRL));
    chk("step_ignored_count", 32'(instr_count), 32'd4);

    // Reset mid-FETCH then mid-EXEC.
    opcode = 6'b000100; run = 1'b1;
    tick();
    #2 reset = 1'b1;
    #1 chk("abort_fetch_ctrl", 32'(ctrl), 32'(IDLE_CTRL));
    tick();
    reset = 1'b0;
    tick();
    tick();
    tick();
    chk("abort_exec_pre", 32'(ctrl), 32'h0B9);
    chk("abort_exec_cnt_pre", 32'(instr_count), 32'd0);
    #2 reset = 1'b1;
    #1 chk("abort_exec_ctrl", 32'(ctrl), 32'(IDLE_CTRL));
    tick();
    reset = 1'b0; run = 1'b0;
    tick();
    chk("abort_count", 32'(instr_count), 32'd0);
    chk("abort_idle_ctrl", 32'(ctrl), 32'(IDLE_CTRL));

    // Halt is absorbing.
    opcode = 6'b111111; run = 1'b1;
    tick();
    tick();
    tick();
    chk("halt_exec_writes", 32'({we3, wez, pc_we}), 32'd0);
    chk("halt_exec_flag", 32'(halted), 32'd0);
    tick();
    chk("halted_set", 32'(halted), 32'd1);
    chk("halt_count", 32'(instr_count), 32'd1);
    for (int c = 0; c < 6; c++) begin
      run = c[0]; step_req = c[1]; opcode = 6'b000100;
      tick();
      chk($sformatf("halt_hold%0d", c), 32'({pc_we, we3, wez, halted}), 32'd1);
      chk($sformatf("halt_cnt%0d", c), 32'(instr_count), 32'd1);
    end
    step_req = 1'b0; run = 1'b0;
    #2 reset = 1'b1;
    #1 chk("halt_reset_flag", 32'(halted), 32'd0);
    chk("halt_reset_count", 32'(instr_count), 32'd0);
    tick();
    reset = 1'b0;

    // Counter wrap at COUNT_W=4 after 17 instructions.
    opcode = 6'b110000; run = 1'b1; n_exec = 0;
    for (int c = 0; c < 200 && n_exec < 17; c++) begin
      tick();
      if (pc_we) n_exec++;
      if (n_exec == 17) run = 1'b0;
    end
    chk("wrap_exec_seen", 32'(n_exec), 32'd17);
    run = 1'b0;
    tick();
    chk("wrap_count", 32'(instr_count), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
